// File: rtl/dsi_lanes_scheduler.sv
// dsi_lanes_scheduler: drives up to four DSI lanes as one link.
// Takes packet beats of one byte per active lane, issues start/finish
// pulses to the active lanes, feeds them in lock-step on their data
// requests, and reports completion once every active lane is back in LP.
// Optional watchdog: define DSI_LANES_SCHEDULER_TIMEOUT_EN.
module dsi_lanes_scheduler #(
  parameter int LANES          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [1:0]           lanes_number,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [LANES-1:0]     lane_start_rqst,
  output logic [LANES-1:0]     lane_fin_rqst,
  output logic [8*LANES-1:0]   lane_data,
  input  logic [LANES-1:0]     lane_data_rqst,
  input  logic [LANES-1:0]     lane_active,
  output logic                 busy,
  output logic                 done,
  output logic                 underflow_err,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SEND   = 3'd2,
    ST_FINISH = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam logic [1:0] LANE_MAX = 2'(LANES - 1);

  // Parameter sanity: lanes are 1..4 and the watchdog limit must fit 8 bits.
  if (LANES < 1 || LANES > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("dsi_lanes_scheduler: parameter out of range");
  end

  // Widen a per-lane mask to a per-byte mask.
  function automatic logic [8*LANES-1:0] expand_mask(input logic [LANES-1:0] m);
    logic [8*LANES-1:0] r;
    r = {(8*LANES){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

  state_t               state_r, state_s;
  logic [LANES-1:0]     mask_r, mask_new_s;
  logic [1:0]           lanes_clamped_s;
  logic                 accept_s, xfer_s, drain_idle_s, timeout_hit_s;
  logic                 busy_r, done_r, underflow_r;
  logic [LANES-1:0]     start_rqst_r, fin_rqst_r;
  logic [8*LANES-1:0]   lane_data_r;

  // Clamp the requested lane count and build the lane mask it implies.
  always_comb begin
    mask_new_s = {LANES{1'b0}};
    if (lanes_number > LANE_MAX) begin
      lanes_clamped_s = LANE_MAX;
    end else begin
      lanes_clamped_s = lanes_number;
    end
    for (int i = 0; i < LANES; i++) begin
      mask_new_s[i] = (2'(i) <= lanes_clamped_s);
    end
  end

  assign accept_s     = (state_r == ST_IDLE) && tx_start;
  // A beat moves only when every masked lane requests; never a partial transfer.
  assign xfer_s       = (state_r == ST_SEND) && (&(lane_data_rqst | ~mask_r));
  assign drain_idle_s = ((lane_active & mask_r) == {LANES{1'b0}});
  assign in_ready     = xfer_s;

`ifdef DSI_LANES_SCHEDULER_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_cnt_r;
  logic       timeout_r;

  // Watchdog fires on the cycle the count would reach the limit without progress.
  always_comb begin
    timeout_hit_s = 1'b0;
    if (wd_cnt_r == WD_LAST) begin
      timeout_hit_s = ((state_r == ST_SEND) && !xfer_s) ||
                      ((state_r == ST_DRAIN) && !drain_idle_s);
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Watchdog counter: restarts entering SEND/DRAIN and on every transfer.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wd_cnt_r  <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r == ST_START || state_r == ST_FINISH || xfer_s) begin
        wd_cnt_r <= 8'd0;
      end else if (state_r == ST_SEND || state_r == ST_DRAIN) begin
        wd_cnt_r <= wd_cnt_r + 8'd1;
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (accept_s) begin
        timeout_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign timeout_err = timeout_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // Next-state logic for the packet sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tx_start) state_s = ST_START;
        else          state_s = ST_IDLE;
      end
      ST_START: state_s = ST_SEND;
      ST_SEND: begin
        if (timeout_hit_s)                    state_s = ST_FINISH;
        else if (xfer_s && in_valid && in_last) state_s = ST_FINISH;
        else                                  state_s = ST_SEND;
      end
      ST_FINISH: state_s = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_idle_s || timeout_hit_s) state_s = ST_IDLE;
        else                               state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus all registered outputs and sticky status.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      mask_r       <= {LANES{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      underflow_r  <= 1'b0;
      start_rqst_r <= {LANES{1'b0}};
      fin_rqst_r   <= {LANES{1'b0}};
      lane_data_r  <= {(8*LANES){1'b0}};
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_r == ST_DRAIN) && (state_s == ST_IDLE);
      start_rqst_r <= accept_s ? mask_new_s : {LANES{1'b0}};
      fin_rqst_r   <= ((state_r == ST_SEND) && (state_s == ST_FINISH)) ? mask_r : {LANES{1'b0}};
      if (accept_s) begin
        mask_r      <= mask_new_s;
        underflow_r <= 1'b0;
        // Clear stale bytes so lanes outside the new mask read 0.
        lane_data_r <= {(8*LANES){1'b0}};
      end else if (xfer_s) begin
        if (in_valid) begin
          lane_data_r <= in_data & expand_mask(mask_r);
        end else begin
          lane_data_r <= {(8*LANES){1'b0}};
          underflow_r <= 1'b1;
        end
      end
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign underflow_err   = underflow_r;
  assign lane_start_rqst = start_rqst_r;
  assign lane_fin_rqst   = fin_rqst_r;
  assign lane_data       = lane_data_r;

endmodule

// File: tb/tb_dsi_lanes_scheduler.sv
// Directed bench for dsi_lanes_scheduler (LANES=4, TIMEOUT_CYCLES=16).
module tb_dsi_lanes_scheduler;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        tx_start;
  logic [1:0]  lanes_number;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  lane_start_rqst;
  logic [3:0]  lane_fin_rqst;
  logic [31:0] lane_data;
  logic [3:0]  lane_data_rqst;
  logic [3:0]  lane_active;
  logic        busy;
  logic        done;
  logic        underflow_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  dsi_lanes_scheduler #(.LANES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_sys         (clk_sys),
    .rst_n           (rst_n),
    .tx_start        (tx_start),
    .lanes_number    (lanes_number),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .lane_start_rqst (lane_start_rqst),
    .lane_fin_rqst   (lane_fin_rqst),
    .lane_data       (lane_data),
    .lane_data_rqst  (lane_data_rqst),
    .lane_active     (lane_active),
    .busy            (busy),
    .done            (done),
    .underflow_err   (underflow_err),
    .timeout_err     (timeout_err)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] beat;

    rst_n = 1'b0; tx_start = 1'b0; lanes_number = 2'd0; in_data = 32'd0;
    in_valid = 1'b0; in_last = 1'b0; lane_data_rqst = 4'h0; lane_active = 4'h0;
    tick(); tick();
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_start", {28'd0, lane_start_rqst}, 32'd0);
    chk("rst_fin",   {28'd0, lane_fin_rqst}, 32'd0);
    chk("rst_data",  lane_data, 32'd0);
    chk("rst_uf",    {31'd0, underflow_err}, 32'd0);
    chk("rst_to",    {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;

    // Four-lane packet, all requests high.
    tx_start = 1'b1; lanes_number = 2'd3;
    tick();
    tx_start = 1'b0;
    chk("p4_start", {28'd0, lane_start_rqst}, 32'h0000000F);
    chk("p4_busy",  {31'd0, busy}, 32'd1);
    lane_data_rqst = 4'hF; lane_active = 4'hF; in_valid = 1'b1;
    #1 chk("p4_rdy_start", {31'd0, in_ready}, 32'd0);
    tick();
    chk("p4_start_end", {28'd0, lane_start_rqst}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) beat[8*k +: 8] = 8'(4*i + k);
      in_data = beat; in_last = (i == 3);
      #1 chk("p4_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      chk("p4_data", lane_data, beat);
    end
    chk("p4_data_last", lane_data, 32'h0F0E0D0C);
    chk("p4_fin", {28'd0, lane_fin_rqst}, 32'h0000000F);
    in_valid = 1'b0; in_last = 1'b0;
    #1 chk("p4_rdy_fin", {31'd0, in_ready}, 32'd0);
    tick();
    chk("p4_fin_end", {28'd0, lane_fin_rqst}, 32'd0);
    chk("p4_drain_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("p4_drain_wait", {31'd0, done}, 32'd0);
    lane_active = 4'h0;
    tick();
    chk("p4_done", {31'd0, done}, 32'd1);
    chk("p4_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("p4_done_pulse", {31'd0, done}, 32'd0);

    // Single lane: upper lanes masked out.
    tx_start = 1'b1; lanes_number = 2'd0; lane_data_rqst = 4'b0001; lane_active = 4'b0001;
    tick();
    tx_start = 1'b0;
    chk("p1_start", {28'd0, lane_start_rqst}, 32'h00000001);
    chk("p1_data_clr", lane_data, 32'd0);
    tick();
    in_valid = 1'b1; in_last = 1'b1; in_data = 32'hAABBCC11;
    #1 chk("p1_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    chk("p1_data", lane_data, 32'h00000011);
    chk("p1_fin", {28'd0, lane_fin_rqst}, 32'h00000001);
    in_valid = 1'b0; in_last = 1'b0; lane_active = 4'b1110;
    tick();
    tick();
    chk("p1_done", {31'd0, done}, 32'd1);
    tick();

    // Skewed requests, tx_start while busy, underflow.
    tx_start = 1'b1; lanes_number = 2'd3; lane_data_rqst = 4'b1011; lane_active = 4'hF;
    tick();
    tx_start = 1'b0;
    chk("sk_start", {28'd0, lane_start_rqst}, 32'h0000000F);
    tick();
    in_valid = 1'b1; in_data = 32'h11223344; in_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tx_start = 1'b1;
      #1 chk("sk_rdy_wait", {31'd0, in_ready}, 32'd0);
      tick();
      chk("sk_no_xfer", lane_data, 32'd0);
      chk("sk_no_restart", {28'd0, lane_start_rqst}, 32'd0);
    end
    tx_start = 1'b0; lane_data_rqst = 4'hF;
    #1 chk("sk_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    chk("sk_data", lane_data, 32'h11223344);
    in_valid = 1'b0;
    #1 chk("uf_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    chk("uf_data", lane_data, 32'd0);
    chk("uf_flag", {31'd0, underflow_err}, 32'd1);
    in_valid = 1'b1; in_data = 32'h55667788; in_last = 1'b1;
    tick();
    chk("uf_last", lane_data, 32'h55667788);
    chk("uf_fin", {28'd0, lane_fin_rqst}, 32'h0000000F);
    chk("uf_sticky", {31'd0, underflow_err}, 32'd1);
    in_valid = 1'b0; in_last = 1'b0; lane_active = 4'h0;
    tick();
    tick();
    chk("uf_done", {31'd0, done}, 32'd1);
    tx_start = 1'b1; lanes_number = 2'd3;
    tick();
    tx_start = 1'b0;
    chk("uf_clear", {31'd0, underflow_err}, 32'd0);

    // Reset mid-SEND.
    tick();
    in_valid = 1'b1; in_data = 32'h99AABBCC; lane_active = 4'hF;
    tick();
    chk("rs_data", lane_data, 32'h99AABBCC);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_data0", lane_data, 32'd0);
    chk("rs_fin", {28'd0, lane_fin_rqst}, 32'd0);
    chk("rs_done", {31'd0, done}, 32'd0);
    #1 chk("rs_rdy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

`ifdef DSI_LANES_SCHEDULER_TIMEOUT_EN
    // Timeout: lanes never request after START.
    lane_data_rqst = 4'h0; lane_active = 4'hF;
    tx_start = 1'b1; lanes_number = 2'd3;
    tick();
    tx_start = 1'b0;
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("to_flag", {31'd0, timeout_err}, 32'd1);
    chk("to_fin", {28'd0, lane_fin_rqst}, 32'h0000000F);
    lane_active = 4'h0;
    tick();
    tick();
    chk("to_done", {31'd0, done}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
